// File: rtl/tx_block_arbiter.sv
// Round-robin, frame-locked arbiter sharing one byte_unpacker between a control
// requester (0) and a cipher-data requester (1), with burst guard and stall watchdog.
module tx_block_arbiter #(
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned STALL_CYCLES = 4096,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [127:0]     req0_block,
  input  logic             req0_valid,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic [127:0]     req1_block,
  input  logic             req1_valid,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic [127:0]     pb_block,
  output logic             pb_load_en,
  input  logic             pb_buffer_ready,
  output logic [1:0]       grant,
  output logic             burst_trunc,
  output logic             stall_err,
  output logic [CNT_W-1:0] blk_count
);

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned WD_W    = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [BLK_W-1:0]   pb_block_q, pb_block_d;
  logic               pb_load_en_q, pb_load_en_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               last_q, last_d;
  logic               burst_trunc_q, burst_trunc_d;
  logic               stall_err_q, stall_err_d;
  logic [CNT_W-1:0]   blk_count_q, blk_count_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic               owner_valid;
  logic               owner_last;
  logic [BLK_W-1:0]   owner_block;
  logic               in_xfer;

  assign in_xfer     = (state_q == XFER);
  assign owner_valid = grant_q[1] ? req1_valid : (grant_q[0] & req0_valid);
  assign owner_last  = grant_q[1] ? req1_last  : req0_last;
  assign owner_block = grant_q[1] ? req1_block : req0_block;

  // Ready is combinational so the owner sees acceptance in the same cycle.
  assign req0_ready  = grant_q[0] & pb_buffer_ready & in_xfer;
  assign req1_ready  = grant_q[1] & pb_buffer_ready & in_xfer;

  assign pb_block    = pb_block_q;
  assign pb_load_en  = pb_load_en_q;
  assign grant       = grant_q;
  assign burst_trunc = burst_trunc_q;
  assign stall_err   = stall_err_q;
  assign blk_count   = blk_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      rr_ptr_q      <= 1'b0;
      pb_block_q    <= '0;
      pb_load_en_q  <= 1'b0;
      burst_q       <= '0;
      last_q        <= 1'b0;
      burst_trunc_q <= 1'b0;
      stall_err_q   <= 1'b0;
      blk_count_q   <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      pb_block_q    <= pb_block_d;
      pb_load_en_q  <= pb_load_en_d;
      burst_q       <= burst_d;
      last_q        <= last_d;
      burst_trunc_q <= burst_trunc_d;
      stall_err_q   <= stall_err_d;
      blk_count_q   <= blk_count_d;
      wd_q          <= wd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    pb_block_d    = pb_block_q;
    pb_load_en_d  = 1'b0;
    burst_d       = burst_q;
    last_d        = last_q;
    burst_trunc_d = burst_trunc_q;
    stall_err_d   = stall_err_q;
    blk_count_d   = blk_count_q;
    wd_d          = '0;

    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (req0_valid && (!req1_valid || rr_ptr_q)) begin
          grant_d  = 2'b01;
          rr_ptr_d = 1'b0;
          state_d  = XFER;
        end else if (req1_valid) begin
          grant_d  = 2'b10;
          rr_ptr_d = 1'b1;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (owner_valid && pb_buffer_ready) begin
          pb_block_d   = owner_block;
          pb_load_en_d = 1'b1;
          blk_count_d  = blk_count_q + CNT_W'(1);
          burst_d      = burst_q + BURST_W'(1);
          last_d       = owner_last;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        // Unpacker ready lags load_en by a cycle, so it is not consulted here.
        if (last_q) begin
          grant_d = 2'b00;
          burst_d = '0;
          state_d = IDLE;
        end else if (burst_q == BURST_W'(MAX_BURST)) begin
          burst_trunc_d = 1'b1;
          grant_d       = 2'b00;
          burst_d       = '0;
          state_d       = IDLE;
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        grant_d = 2'b00;
        burst_d = '0;
        state_d = IDLE;
      end
    endcase

    // Saturating count of consecutive stalled owner cycles.
    if (in_xfer && owner_valid && !pb_buffer_ready) begin
      wd_d = (wd_q == WD_W'(STALL_CYCLES)) ? wd_q : wd_q + WD_W'(1);
      if (wd_d == WD_W'(STALL_CYCLES)) stall_err_d = 1'b1;
    end
  end

endmodule
